pr_iter_sched: RTL and testbench

//  Iteration scheduler for one PageRank ant (N local pages of M global pages).

---
 rtl/pr_iter_sched.sv | 189 ++++++++++++++++++
 tb/tb_pr_iter_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_iter_sched.sv
// Iteration scheduler for one PageRank ant.
// Each iteration strobes every local page once, then walks the global page
// space and issues one NoC request per linked remote page, waiting for the
// matching response (or a timeout) before moving to the next candidate.
// Handshake: a request transfers on a cycle where req_valid and req_ready
// are both high; req_page is held stable while req_valid waits for
// req_ready. A response is taken only when rsp_valid is high and rsp_page
// equals the outstanding req_page.
module pr_iter_sched #(
  parameter int N       = 16,
  parameter int M       = 64,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   num_iter,
  input  logic [1:0]   id,
  input  logic [M-1:0] remote_mask,
  output logic         upd_valid,
  output logic [5:0]   upd_page,
  output logic         req_valid,
  output logic [5:0]   req_page,
  input  logic         req_ready,
  input  logic         rsp_valid,
  input  logic [5:0]   rsp_page,
  output logic         busy,
  output logic         done,
  output logic [7:0]   iter_cnt,
  output logic         timeout_err
);

  // WIDTH is carried only so the datapath parameter set stays uniform; it
  // does not shape any logic here, so it is folded in with zero weight.
  localparam int PW = $clog2(M);
  localparam int GW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1) + (WIDTH * 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOCAL = 3'd1,
    S_SCAN  = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t        state_q;
  logic [GW-1:0] g_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    num_iter_q;
  logic [7:0]    iter_cnt_q;
  logic          upd_valid_q;
  logic [5:0]    upd_page_q;
  logic          req_valid_q;
  logic [5:0]    req_page_q;
  logic          busy_q;
  logic          done_q;
  logic          timeout_err_q;

  logic [GW-1:0] own_lo;
  logic          in_own;
  logic          eligible;
  logic          g_last;
  logic          rsp_match;
  logic          tmo_hit;
  logic [GW-1:0] g_d;
  logic [7:0]    iter_cnt_d;

  // Candidate qualification, scan-wrap detection and counter next values.
  always_comb begin
    own_lo     = GW'(id) * GW'(N);
    in_own     = (g_q >= own_lo) && (g_q < own_lo + GW'(N));
    eligible   = remote_mask[g_q[PW-1:0]] && !in_own;
    g_last     = (g_q == GW'(M - 1));
    g_d        = g_q + GW'(1);
    rsp_match  = rsp_valid && (rsp_page == req_page_q);
    tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
    iter_cnt_d = (iter_cnt_q == 8'hFF) ? 8'hFF : iter_cnt_q + 8'd1;
  end

  // Scheduler FSM; every output is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      g_q           <= '0;
      tmo_q         <= '0;
      num_iter_q    <= '0;
      iter_cnt_q    <= '0;
      upd_valid_q   <= 1'b0;
      upd_page_q    <= '0;
      req_valid_q   <= 1'b0;
      req_page_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_iter_q    <= num_iter;
            iter_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            if (num_iter == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_LOCAL;
              upd_valid_q <= 1'b1;
              upd_page_q  <= '0;
            end
          end
        end
        S_LOCAL: begin
          // upd_page_q doubles as the local page index.
          if (upd_page_q == 6'(N - 1)) begin
            upd_valid_q <= 1'b0;
            g_q         <= '0;
            state_q     <= S_SCAN;
          end else begin
            upd_page_q <= upd_page_q + 6'd1;
          end
        end
        S_SCAN: begin
          if (eligible) begin
            req_valid_q <= 1'b1;
            req_page_q  <= 6'(g_q);
            state_q     <= S_REQ;
          end else if (g_last) begin
            state_q <= S_NEXT;
          end else begin
            g_q <= g_d;
          end
        end
        S_REQ: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            tmo_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A matching response wins over a timeout in the same cycle.
          if (rsp_match || tmo_hit) begin
            if (!rsp_match) timeout_err_q <= 1'b1;
            if (g_last) begin
              state_q <= S_NEXT;
            end else begin
              g_q     <= g_d;
              state_q <= S_SCAN;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_NEXT: begin
          iter_cnt_q <= iter_cnt_d;
          if (iter_cnt_d == num_iter_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= S_LOCAL;
            upd_valid_q <= 1'b1;
            upd_page_q  <= '0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_page    = upd_page_q;
  assign req_valid   = req_valid_q;
  assign req_page    = req_page_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign iter_cnt    = iter_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pr_iter_sched.sv
// Directed bench for pr_iter_sched with an update/request scoreboard.
module tb_pr_iter_sched;

  localparam int N       = 16;
  localparam int M       = 64;
  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   num_iter;
  logic [1:0]   id;
  logic [M-1:0] remote_mask;
  logic         upd_valid;
  logic [5:0]   upd_page;
  logic         req_valid;
  logic [5:0]   req_page;
  logic         req_ready;
  logic         rsp_valid;
  logic [5:0]   rsp_page;
  logic         busy;
  logic         done;
  logic [7:0]   iter_cnt;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_upd_q[$];
  logic [5:0] exp_req_q[$];
  int ncyc     = 0;
  int done_cnt = 0;
  int req_cyc  = 0;
  int p0_first = -1;
  int p0_last  = -1;

  pr_iter_sched #(.N(N), .M(M), .WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_iter    (num_iter),
    .id          (id),
    .remote_mask (remote_mask),
    .upd_valid   (upd_valid),
    .upd_page    (upd_page),
    .req_valid   (req_valid),
    .req_page    (req_page),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_page    (rsp_page),
    .busy        (busy),
    .done        (done),
    .iter_cnt    (iter_cnt),
    .timeout_err (timeout_err)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled
  // on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_upd(input int iters);
    for (int it = 0; it < iters; it++)
      for (int p = 0; p < N; p++) exp_upd_q.push_back(6'(p));
  endtask

  task automatic clear_stats();
    done_cnt = 0;
    req_cyc  = 0;
    p0_first = -1;
    p0_last  = -1;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    num_iter = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // NoC responder: serves requests until the run leaves busy.
  task automatic serve(input int budget, input int hold_page, input int hold_n,
                       input int wrong_for, input int drop_page);
    int cyc;
    int held;
    int good_cyc;
    int wrong_cyc;
    logic [5:0] good_pg;
    logic [5:0] wrong_pg;
    cyc = 0; held = 0; good_cyc = -1; wrong_cyc = -1;
    good_pg = '0; wrong_pg = '0;
    while (busy === 1'b1 && cyc < budget) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_page  = '0;
      if (cyc == wrong_cyc) begin rsp_valid = 1'b1; rsp_page = wrong_pg; end
      if (cyc == good_cyc)  begin rsp_valid = 1'b1; rsp_page = good_pg;  end
      if (req_valid === 1'b1) begin
        check("req_before_rsp", 32'(good_cyc > cyc), 32'd0);
        if (int'(req_page) == hold_page && held < hold_n) begin
          held++;
        end else begin
          req_ready = 1'b1;
          if (int'(req_page) != drop_page) begin
            good_pg = req_page;
            if (int'(req_page) == wrong_for) begin
              wrong_pg  = req_page + 6'd1;
              wrong_cyc = cyc + 1;
              good_cyc  = cyc + 5;
            end else begin
              good_cyc = cyc + 2;
            end
          end
        end
      end
      tick();
      cyc++;
    end
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    check("run_in_budget", 32'(cyc < budget), 32'd1);
  endtask

  // Scoreboard: pops expected strobes/requests as the DUT produces them.
  always @(negedge clk) begin
    ncyc++;
    if (reset === 1'b0) begin
      if (upd_valid || req_valid) check("no_overlap", 32'(upd_valid & req_valid), 32'd0);
      if (upd_valid) begin
        if (upd_page == 6'd0) begin
          if (p0_first < 0) p0_first = ncyc;
          else p0_last = ncyc;
        end
        if (exp_upd_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL upd_extra: observed strobe for page %0d expected no strobe", upd_page);
        end else begin
          check("upd_page", 32'(upd_page), 32'(exp_upd_q.pop_front()));
        end
      end
      if (req_valid) begin
        req_cyc++;
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL req_extra: observed request for page %0d expected no request", req_page);
        end else begin
          check("req_page", 32'(req_page), 32'(exp_req_q[0]));
          if (req_ready) void'(exp_req_q.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    logic [M-1:0] mask3;
    reset       = 1'b1;
    start       = 1'b0;
    num_iter    = '0;
    id          = '0;
    remote_mask = '0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_page    = '0;
    mask3       = '0;
    mask3[3]    = 1'b1;
    mask3[20]   = 1'b1;
    mask3[63]   = 1'b1;
    tick();
    tick();

    // Reset values
    check("rst_valids", 32'({upd_valid, req_valid, busy, done, timeout_err}), 32'd0);
    check("rst_upd_page", 32'(upd_page), 32'd0);
    check("rst_req_page", 32'(req_page), 32'd0);
    check("rst_iter_cnt", 32'(iter_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of the local phase, at local page 5
    id = 2'd1;
    remote_mask = '0;
    clear_stats();
    for (int p = 0; p < 5; p++) exp_upd_q.push_back(6'(p));
    pulse_start(8'd3);
    for (int n = 0; n < 50 && !(upd_valid === 1'b1 && upd_page == 6'd5); n++) tick();
    check("mid_local_lp5", 32'(upd_valid === 1'b1 && upd_page == 6'd5), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_valids", 32'({upd_valid, req_valid, busy, done, timeout_err}), 32'd0);
    check("midrst_pages", 32'({upd_page, req_page}), 32'd0);
    check("midrst_iter_cnt", 32'(iter_cnt), 32'd0);
    check("midrst_upd_left", 32'(exp_upd_q.size()), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("after_rst_idle", 32'(busy), 32'd0);

    // Two iterations, no remote pages
    clear_stats();
    push_upd(2);
    pulse_start(8'd2);
    serve(400, -1, 0, -1, -1);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_iter_cnt", 32'(iter_cnt), 32'd2);
    check("t2_req_cycles", 32'(req_cyc), 32'd0);
    check("t2_iter_len", 32'(p0_last - p0_first), 32'(N + M + 1));
    check("t2_upd_left", 32'(exp_upd_q.size()), 32'd0);

    // Remote pages 3, 20, 63 with id 0: page 3 is local
    id = 2'd0;
    remote_mask = mask3;
    clear_stats();
    push_upd(1);
    exp_req_q.push_back(6'd20);
    exp_req_q.push_back(6'd63);
    pulse_start(8'd1);
    serve(600, -1, 0, -1, -1);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_iter_cnt", 32'(iter_cnt), 32'd1);
    check("t3_req_left", 32'(exp_req_q.size()), 32'd0);
    check("t3_timeout_err", 32'(timeout_err), 32'd0);

    // Backpressure on page 20 and a stray response for page 21
    remote_mask = mask3;
    remote_mask[21] = 1'b1;
    clear_stats();
    push_upd(1);
    exp_req_q.push_back(6'd20);
    exp_req_q.push_back(6'd21);
    exp_req_q.push_back(6'd63);
    pulse_start(8'd1);
    serve(600, 20, 4, 20, -1);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);
    check("t4_req_cycles", 32'(req_cyc), 32'd7);
    check("t4_req_left", 32'(exp_req_q.size()), 32'd0);
    check("t4_timeout_err", 32'(timeout_err), 32'd0);

    // No response for page 63: timeout, run still completes
    remote_mask = mask3;
    clear_stats();
    push_upd(1);
    exp_req_q.push_back(6'd20);
    exp_req_q.push_back(6'd63);
    pulse_start(8'd1);
    serve(1000, -1, 0, -1, 63);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_iter_cnt", 32'(iter_cnt), 32'd1);
    check("t5_timeout_err", 32'(timeout_err), 32'd1);
    check("t5_req_left", 32'(exp_req_q.size()), 32'd0);

    // Zero iterations; this start also clears the sticky timeout flag
    clear_stats();
    pulse_start(8'd0);
    check("t6_done", 32'(done), 32'd1);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_timeout_clr", 32'(timeout_err), 32'd0);
    check("t6_iter_cnt", 32'(iter_cnt), 32'd0);
    tick();
    check("t6_done_end", 32'({done, busy}), 32'd0);
    tick();
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
    check("t6_req_cycles", 32'(req_cyc), 32'd0);
    check("t6_upd_left", 32'(exp_upd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
